// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the light controller and the lamp drivers: registers commanded lights, latches a flashing fault on persistent conflicts.
// Optional input-stall watchdog is built when TRAFFIC_CONFLICT_MON_WATCHDOG_EN is defined.
module traffic_conflict_monitor #(
  parameter int PERSIST    = 2,
  parameter int STARTUP    = 3,
  parameter int BLINK_HALF = 4
`ifdef TRAFFIC_CONFLICT_MON_WATCHDOG_EN
  ,parameter int WDOG_CYCLES = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       clear,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_S,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_cnt
);

  localparam logic [2:0]  RED      = 3'b100;
  localparam logic [2:0]  YEL      = 3'b010;
  localparam logic [2:0]  GRN      = 3'b001;
  localparam logic [11:0] ALL_RED  = {RED, RED, RED, RED};
  localparam logic [11:0] FLASH_ON = {YEL, YEL, RED, RED};

  typedef enum logic [1:0] {ST_START, ST_PASS, ST_FAULT} state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_lamp, w_lamp_nxt;
  logic        r_fault, w_fault_nxt;
  logic [2:0]  r_code, w_code_nxt;
  logic [7:0]  r_fcnt, w_fcnt_nxt;
  logic [3:0]  r_start_cnt, w_start_cnt_nxt;
  logic [3:0]  r_pers_cnt, w_pers_cnt_nxt;
  logic [7:0]  r_blink_cnt, w_blink_cnt_nxt;
  logic        r_blink_on, w_blink_on_nxt;
  logic [11:0] w_in;
  logic [2:0]  w_chk;
  logic        w_trip;
  logic [2:0]  w_trip_code;
  logic        w_wd_hit;

  assign w_in = {light_M1, light_M2, light_MT, light_S};

  function automatic logic is_legal(input logic [2:0] v);
    return (v == RED) || (v == YEL) || (v == GRN);
  endfunction

  always_comb begin
    w_chk = 3'b000;
    if (!(is_legal(light_M1) && is_legal(light_M2) && is_legal(light_MT) && is_legal(light_S)))
      w_chk = 3'b001;
    else if ((light_S != RED) && ((light_M1 != RED) || (light_M2 != RED) || (light_MT != RED)))
      w_chk = 3'b010;
    else if ((light_MT != RED) && (light_M2 != RED))
      w_chk = 3'b011;
  end

`ifdef TRAFFIC_CONFLICT_MON_WATCHDOG_EN
  logic [11:0] r_prev;
  logic [9:0]  r_wd_cnt, w_wd_cnt_nxt;
  logic        w_same;
  assign w_same   = (w_in == r_prev);
  assign w_wd_hit = (r_state == ST_PASS) && w_same && ((r_wd_cnt + 10'd1) == 10'(WDOG_CYCLES));
`else
  assign w_wd_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_lamp_nxt      = r_lamp;
    w_fault_nxt     = r_fault;
    w_code_nxt      = r_code;
    w_fcnt_nxt      = r_fcnt;
    w_start_cnt_nxt = r_start_cnt;
    w_pers_cnt_nxt  = r_pers_cnt;
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_on_nxt  = r_blink_on;
    w_trip          = 1'b0;
    w_trip_code     = w_chk;
`ifdef TRAFFIC_CONFLICT_MON_WATCHDOG_EN
    w_wd_cnt_nxt    = 10'd0;
`endif
    case (r_state)
      ST_START: begin
        // Controller outputs are undefined here, so inputs are not looked at.
        w_lamp_nxt = ALL_RED;
        if (r_start_cnt == 4'(STARTUP - 1)) begin
          w_state_nxt     = ST_PASS;
          w_start_cnt_nxt = 4'd0;
          w_pers_cnt_nxt  = 4'd0;
        end else begin
          w_start_cnt_nxt = r_start_cnt + 4'd1;
        end
      end
      ST_PASS: begin
`ifdef TRAFFIC_CONFLICT_MON_WATCHDOG_EN
        w_wd_cnt_nxt = w_same ? (r_wd_cnt + 10'd1) : 10'd0;
`endif
        if (w_chk == 3'b000) begin
          w_lamp_nxt     = w_in;
          w_pers_cnt_nxt = 4'd0;
        end else begin
          w_pers_cnt_nxt = r_pers_cnt + 4'd1;
          if ((r_pers_cnt + 4'd1) == 4'(PERSIST))
            w_trip = 1'b1;
        end
        if (!w_trip && w_wd_hit) begin
          w_trip      = 1'b1;
          w_trip_code = 3'b100;
        end
        if (w_trip) begin
          w_state_nxt     = ST_FAULT;
          w_fault_nxt     = 1'b1;
          w_code_nxt      = w_trip_code;
          w_fcnt_nxt      = (r_fcnt == 8'hFF) ? r_fcnt : (r_fcnt + 8'd1);
          w_blink_on_nxt  = 1'b1;
          w_blink_cnt_nxt = 8'd0;
          w_lamp_nxt      = FLASH_ON;
          w_pers_cnt_nxt  = 4'd0;
        end
      end
      ST_FAULT: begin
        if (clear && (w_chk == 3'b000)) begin
          w_state_nxt     = ST_START;
          w_fault_nxt     = 1'b0;
          w_code_nxt      = 3'b000;
          w_lamp_nxt      = ALL_RED;
          w_start_cnt_nxt = 4'd0;
        end else if (r_blink_cnt == 8'(BLINK_HALF - 1)) begin
          w_blink_cnt_nxt = 8'd0;
          w_blink_on_nxt  = !r_blink_on;
          w_lamp_nxt      = r_blink_on ? 12'd0 : FLASH_ON;
        end else begin
          w_blink_cnt_nxt = r_blink_cnt + 8'd1;
          w_lamp_nxt      = r_blink_on ? FLASH_ON : 12'd0;
        end
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_START;
      r_lamp      <= ALL_RED;
      r_fault     <= 1'b0;
      r_code      <= 3'b000;
      r_fcnt      <= 8'd0;
      r_start_cnt <= 4'd0;
      r_pers_cnt  <= 4'd0;
      r_blink_cnt <= 8'd0;
      r_blink_on  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lamp      <= w_lamp_nxt;
      r_fault     <= w_fault_nxt;
      r_code      <= w_code_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_start_cnt <= w_start_cnt_nxt;
      r_pers_cnt  <= w_pers_cnt_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink_on  <= w_blink_on_nxt;
    end
  end

`ifdef TRAFFIC_CONFLICT_MON_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev   <= 12'd0;
      r_wd_cnt <= 10'd0;
    end else begin
      r_prev   <= w_in;
      r_wd_cnt <= w_wd_cnt_nxt;
    end
  end
`endif

  assign lamp_M1    = r_lamp[11:9];
  assign lamp_M2    = r_lamp[8:6];
  assign lamp_MT    = r_lamp[5:3];
  assign lamp_S     = r_lamp[2:0];
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign fault_cnt  = r_fcnt;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Randomized bench for traffic_conflict_monitor against a behavioural model, plus hand-computed checkpoints.
module tb_traffic_conflict_monitor;
  localparam int PERSIST     = 2;
  localparam int STARTUP     = 3;
  localparam int BLINK_HALF  = 4;
  localparam int WDOG_CYCLES = 32;

  localparam logic [11:0] ALL_RED  = 12'h924; // 100 100 100 100
  localparam logic [11:0] FLASH_ON = 12'h4A4; // 010 010 100 100
  localparam logic [11:0] S1       = 12'h264; // 001 001 100 100
  localparam logic [11:0] LEGAL [7] = '{12'h264, 12'h4A4, 12'h30C, 12'h921, 12'h922, 12'h924, 12'h324};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] li [4];
  logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_cnt;

  int errors = 0;
  int checks = 0;

  traffic_conflict_monitor dut (
    .clk(clk), .rst(rst),
    .light_M1(li[0]), .light_M2(li[1]), .light_MT(li[2]), .light_S(li[3]),
    .clear(clear),
    .lamp_M1(lamp_M1), .lamp_M2(lamp_M2), .lamp_MT(lamp_MT), .lamp_S(lamp_S),
    .fault(fault), .fault_code(fault_code), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = start-up red, 1 = pass-through, 2 = flashing fault.
  int         m_mode, m_start_n, m_consec, m_age, m_same_run, m_cnt;
  logic [2:0] m_lamp [4];
  logic [2:0] m_prev [4];
  logic       m_fault;
  logic [2:0] m_code;

  function automatic bit one_hot(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

  function automatic int code_of(input logic [2:0] m1, m2, mt, s);
    if (!(one_hot(m1) && one_hot(m2) && one_hot(mt) && one_hot(s))) return 1;
    if (s != 3'b100 && (m1 != 3'b100 || m2 != 3'b100 || mt != 3'b100)) return 2;
    if (mt != 3'b100 && m2 != 3'b100) return 3;
    return 0;
  endfunction

  task automatic set_lamps(input logic [11:0] v);
    m_lamp[0] = v[11:9]; m_lamp[1] = v[8:6]; m_lamp[2] = v[5:3]; m_lamp[3] = v[2:0];
  endtask

  task automatic model_reset();
    m_mode = 0; m_start_n = 0; m_consec = 0; m_age = 0; m_same_run = 0; m_cnt = 0;
    m_fault = 1'b0; m_code = 3'b000;
    set_lamps(ALL_RED);
    for (int i = 0; i < 4; i++) m_prev[i] = 3'b000;
  endtask

  task automatic enter_fault(input int c);
    m_mode = 2; m_fault = 1'b1; m_code = 3'(c); m_age = 0;
    if (m_cnt < 255) m_cnt = m_cnt + 1;
    set_lamps(FLASH_ON);
  endtask

  task automatic model_step();
    int  c;
    bit  same;
    c = code_of(li[0], li[1], li[2], li[3]);
    same = 1'b1;
    for (int i = 0; i < 4; i++) if (li[i] != m_prev[i]) same = 1'b0;
    if (m_mode == 0) begin
      set_lamps(ALL_RED);
      m_start_n = m_start_n + 1;
      if (m_start_n == STARTUP) begin
        m_mode = 1; m_consec = 0; m_same_run = 0;
      end
    end else if (m_mode == 1) begin
      m_same_run = same ? m_same_run + 1 : 0;
      if (c == 0) begin
        for (int i = 0; i < 4; i++) m_lamp[i] = li[i];
        m_consec = 0;
      end else begin
        m_consec = m_consec + 1;
      end
      if (c != 0 && m_consec == PERSIST) enter_fault(c);
`ifdef TRAFFIC_CONFLICT_MON_WATCHDOG_EN
      else if (m_same_run == WDOG_CYCLES) enter_fault(4);
`endif
    end else begin
      if (clear && c == 0) begin
        m_mode = 0; m_start_n = 0; m_fault = 1'b0; m_code = 3'b000;
        set_lamps(ALL_RED);
      end else begin
        m_age = m_age + 1;
        if (((m_age / BLINK_HALF) % 2) == 0) set_lamps(FLASH_ON);
        else set_lamps(12'h000);
      end
    end
    for (int i = 0; i < 4; i++) m_prev[i] = li[i];
  endtask

  function automatic logic [11:0] dut_lamps();
    return {lamp_M1, lamp_M2, lamp_MT, lamp_S};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("lamps", dut_lamps(), {m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3]});
    chk("fault", 12'(fault), 12'(m_fault));
    chk("fault_code", 12'(fault_code), 12'(m_code));
    chk("fault_cnt", 12'(fault_cnt), 12'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic set_in(input logic [11:0] v);
    li[0] = v[11:9]; li[1] = v[8:6]; li[2] = v[5:3]; li[3] = v[2:0];
  endtask

  task automatic async_reset(input string name);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk({name, "_lamps"}, dut_lamps(), ALL_RED);
    chk({name, "_fault"}, 12'(fault), 12'd0);
    chk({name, "_code"}, 12'(fault_code), 12'd0);
    chk({name, "_cnt"}, 12'(fault_cnt), 12'd0);
    #2 rst = 1'b0;
  endtask

  initial begin
    set_in(S1);
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("reset_lamps", dut_lamps(), ALL_RED);
    chk("reset_fault", 12'(fault), 12'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start-up red, then pass-through with one cycle of lag.
    for (int i = 0; i < STARTUP; i++) begin
      tick();
      chk("startup_red", dut_lamps(), ALL_RED);
    end
    tick();
    chk("first_pass", dut_lamps(), S1);

    // Single conflicting cycle is masked, two consecutive trip with code 010.
    li[3] = 3'b001;
    tick();
    chk("hold_on_conflict", dut_lamps(), S1);
    chk("no_trip_single", 12'(fault), 12'd0);
    li[3] = 3'b100;
    tick();
    li[3] = 3'b001;
    tick();
    chk("no_trip_after_gap", 12'(fault), 12'd0);
    tick();
    chk("trip_fault", 12'(fault), 12'd1);
    chk("trip_code", 12'(fault_code), 12'd2);
    chk("trip_cnt", 12'(fault_cnt), 12'd1);
    chk("trip_flash", dut_lamps(), FLASH_ON);

    // Clear is ignored while the conflict persists.
    clear = 1'b1;
    tick();
    tick();
    chk("clear_ignored", 12'(fault), 12'd1);
    li[3] = 3'b100;
    tick();
    chk("clear_fault", 12'(fault), 12'd0);
    chk("clear_red", dut_lamps(), ALL_RED);
    clear = 1'b0;
    for (int i = 0; i < STARTUP; i++) tick();
    chk("clear_restart_red", dut_lamps(), ALL_RED);
    tick();
    chk("clear_pass", dut_lamps(), S1);

    // Illegal encoding: code 001, then the flash cadence.
    li[1] = 3'b011;
    tick();
    tick();
    chk("illegal_code", 12'(fault_code), 12'd1);
    chk("illegal_cnt", 12'(fault_cnt), 12'd2);
    for (int i = 0; i < BLINK_HALF - 1; i++) tick();
    chk("flash_on_end", dut_lamps(), FLASH_ON);
    tick();
    chk("flash_off", dut_lamps(), 12'h000);
    for (int i = 0; i < BLINK_HALF; i++) tick();
    chk("flash_on_again", dut_lamps(), FLASH_ON);

    // Randomized traffic with occasional conflicts, clears and resets.
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        // hold current inputs
      end else if (r < 85) begin
        set_in(LEGAL[$urandom_range(0, 6)]);
      end else begin
        li[$urandom_range(0, 3)] = 3'($urandom_range(0, 7));
      end
      clear = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 699) == 0) async_reset("rand_rst");
      tick();
    end

    // Asynchronous reset in the middle of a fault.
    clear = 1'b0;
    async_reset("pre_rst");
    set_in(S1);
    for (int i = 0; i < STARTUP + 1; i++) tick();
    li[2] = 3'b001;
    tick();
    tick();
    chk("mid_fault_code", 12'(fault_code), 12'd3);
    async_reset("mid_fault_rst");
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Safety stage sitting directly downstream of the traffic light controller, between its four 3-bit light outputs and the lamp drivers. Registers the commanded lights through to the lamps while checking every cycle for illegal codes and conflicting green/yellow combinations. On a persistent conflict it latches a fault and overrides all heads with a flashing fail-safe pattern until an explicit clear.

## Interface
- PERSIST, 2: consecutive conflicting cycles required to trip (1..15)
- STARTUP, 3: cycles all heads are forced red after reset or clear (1..15)
- BLINK_HALF, 4: cycles per half-period of the fault flash (1..255)
- WDOG_CYCLES, 32: unchanged-input limit for the watchdog (2..1023, only with the macro)
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- light_M1, light_M2, light_MT, light_S  in  3 each  commanded lights from the controller; 100 red, 010 yellow, 001 green
- clear  in  1  level, requests fault exit
- lamp_M1, lamp_M2, lamp_MT, lamp_S  out  3 each  registered lamp drive; same encoding, 000 = dark
- fault  out  1  latched fault flag
- fault_code  out  3  cause of the latched fault
- fault_cnt  out  8  saturating count of fault entries

## Operation
- Per-cycle check on the inputs, with priority top-down:
  - Any input not in {100,010,001}: code 001.
  - light_S not red while any of M1, M2, MT is not red: code 010.
  - light_MT not red while light_M2 is not red: code 011.
- M1 with M2 non-red together is legal. M1 with MT non-red together is legal.
- States: START, PASS, FAULT.
- START:
  - All lamps 100.
  - Inputs are ignored, because controller lights are undefined after reset.
  - After STARTUP cycles, go to PASS with the persistence count at 0.
- PASS, input legal:
  - Lamps take the inputs.
  - Persistence count goes to 0.
- PASS, input conflicting:
  - Lamps hold their previous value. A conflicting code never reaches the lamps.
  - Persistence count increments.
  - When the count reaches PERSIST, go to FAULT.
- Entering FAULT:
  - fault set to 1.
  - fault_code is the code of the tripping cycle.
  - fault_cnt increments, saturating at 255.
  - Blink phase set to on, blink counter set to 0.
- FAULT:
  - Phase on: lamp_M1 = lamp_M2 = 010, lamp_MT = lamp_S = 100.
  - Phase off: all lamps 000.
  - Phase toggles every BLINK_HALF cycles.
  - clear is sampled each cycle. If clear = 1 and the current inputs are legal, go to START: fault = 0, fault_code = 000, all lamps 100.
  - clear with conflicting inputs is ignored.
- clear in START or PASS has no effect.

## Timing
- Reset values:
  - State START, all counters 0.
  - lamp_* = 100, fault = 0, fault_code = 000, fault_cnt = 0.
- Reset is asynchronous. Asserting it mid-FAULT or mid-PASS immediately forces the reset values.
- fault_cnt is cleared only by rst.
- PASS latency: one cycle. Inputs sampled at edge k appear on the lamps after edge k.
- First PASS sample occurs at edge STARTUP+1 after reset release.
- Trip timing:
  - The conflict must be present on PERSIST consecutive sampling edges.
  - fault and the flash pattern appear after the PERSIST-th edge.
  - A single legal sample in between restarts the count.
- Clear timing: clear sampled at edge k gives START outputs after edge k. Lamps pass inputs again after edge k+STARTUP+1.
- When a trip and clear coincide (in PASS), the trip wins because clear is ignored in PASS.

## Configuration
- TRAFFIC_CONFLICT_MON_WATCHDOG_EN defined:
  - In PASS, a 10-bit counter increments while all four inputs equal the previous cycle's inputs, and resets on any change.
  - Reaching WDOG_CYCLES trips FAULT with code 100. A conflict trip on the same edge takes priority.
- Undefined: no watchdog logic, and code 100 is never produced.

## Test plan
- Reset, then drive legal S1 lights (M1=M2=001, MT=S=100) -> lamps 100 for 3 cycles, then lamps = inputs with 1-cycle lag, fault = 0.
- In PASS drive light_S = 001 with M1 = 001 for exactly 1 cycle -> lamps hold previous value, no fault. For 2 cycles -> fault = 1, fault_code = 010, fault_cnt = 1.
- Drive light_M2 = 011 for 2 cycles -> fault_code = 001. Then lamps alternate between (010,010,100,100) and all-000 every 4 cycles.
- In FAULT, assert clear while conflict persists -> stays in FAULT. Restore legal inputs with clear = 1 -> fault = 0, lamps 100 for 3 cycles, then pass-through.
- Assert rst mid-FAULT -> lamps 100, fault = 0, fault_code = 000, fault_cnt = 0 without waiting for clk.
- With TRAFFIC_CONFLICT_MON_WATCHDOG_EN, hold legal inputs constant for 32 cycles -> fault_code = 100. Toggle inputs every 8 cycles -> no fault.
